// File: rtl/axi_wr_arbiter_pkg.sv
// Shared definitions for the AXI4-lite write arbiter: FSM state encoding and
// AXI response codes.
package axi_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_wr_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping,
// returned as a one-hot grant plus its binary index.
module ysyx_24110006_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   any_req
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand_s;
    logic          found_s;

    // Walk the candidates in priority order starting at ptr and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_s = {1'b0, ptr} + CW'(k);
            if (cand_s >= CW'(NUM_MASTERS)) begin
                cand_s = cand_s - CW'(NUM_MASTERS);
            end else begin
                cand_s = cand_s;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!found_s && req[j] && (cand_s == CW'(j))) begin
                    found_s   = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                end else begin
                    found_s = found_s;
                end
            end
        end
        any_req = found_s;
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite write slave among several masters;
// one full AW/W/B transaction is granted at a time.
module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_awaddr,
    input  logic [NUM_MASTERS-1:0]        i_m_awvalid,
    output logic [NUM_MASTERS-1:0]        o_m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] i_m_wstrb,
    input  logic [NUM_MASTERS-1:0]        i_m_wvalid,
    output logic [NUM_MASTERS-1:0]        o_m_wready,
    output logic [NUM_MASTERS*2-1:0]      o_m_bresp,
    output logic [NUM_MASTERS-1:0]        o_m_bvalid,
    input  logic [NUM_MASTERS-1:0]        i_m_bready,
    output logic [ADDR_W-1:0]             o_s_awaddr,
    output logic                          o_s_awvalid,
    input  logic                          i_s_awready,
    output logic [DATA_W-1:0]             o_s_wdata,
    output logic [STRB_W-1:0]             o_s_wstrb,
    output logic                          o_s_wvalid,
    input  logic                          i_s_wready,
    input  logic [1:0]                    i_s_bresp,
    input  logic                          i_s_bvalid,
    output logic                          o_s_bready
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_e             state_r, state_n;
    logic [NUM_MASTERS-1:0] grant_r, grant_n;
    logic [IDX_W-1:0]       grant_idx_r, grant_idx_n;
    logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_n;
    logic                   aw_done_r, aw_done_n;
    logic                   w_done_r, w_done_n;

    logic [NUM_MASTERS-1:0] arb_grant_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_any_s;

    logic [ADDR_W-1:0]      sel_awaddr_s;
    logic [DATA_W-1:0]      sel_wdata_s;
    logic [STRB_W-1:0]      sel_wstrb_s;
    logic                   sel_awvalid_s;
    logic                   sel_wvalid_s;
    logic                   sel_bready_s;
    logic                   aw_act_s;
    logic                   w_act_s;
    logic                   resp_s;
    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   b_hs_s;

    ysyx_24110006_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr (
        .req       (i_m_awvalid),
        .ptr       (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any_req   (arb_any_s)
    );

    // One-hot mux of the granted master's request-side fields.
    always_comb begin
        sel_awaddr_s  = '0;
        sel_wdata_s   = '0;
        sel_wstrb_s   = '0;
        sel_awvalid_s = 1'b0;
        sel_wvalid_s  = 1'b0;
        sel_bready_s  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_r[i]) begin
                sel_awaddr_s  = i_m_awaddr[i*ADDR_W +: ADDR_W];
                sel_wdata_s   = i_m_wdata[i*DATA_W +: DATA_W];
                sel_wstrb_s   = i_m_wstrb[i*STRB_W +: STRB_W];
                sel_awvalid_s = i_m_awvalid[i];
                sel_wvalid_s  = i_m_wvalid[i];
                sel_bready_s  = i_m_bready[i];
            end else begin
                sel_awaddr_s = sel_awaddr_s;
            end
        end
    end

    // Slave-side drive and per-master demux; everything outside the active phase is zero.
    always_comb begin
        aw_act_s    = (state_r == ST_XFER) && !aw_done_r;
        w_act_s     = (state_r == ST_XFER) && !w_done_r;
        resp_s      = (state_r == ST_RESP);
        o_s_awvalid = aw_act_s && sel_awvalid_s;
        o_s_awaddr  = aw_act_s ? sel_awaddr_s : {ADDR_W{1'b0}};
        o_s_wvalid  = w_act_s && sel_wvalid_s;
        o_s_wdata   = w_act_s ? sel_wdata_s : {DATA_W{1'b0}};
        o_s_wstrb   = w_act_s ? sel_wstrb_s : {STRB_W{1'b0}};
        o_s_bready  = resp_s && sel_bready_s;
        aw_hs_s     = o_s_awvalid && i_s_awready;
        w_hs_s      = o_s_wvalid && i_s_wready;
        b_hs_s      = o_s_bready && i_s_bvalid;
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_bvalid  = '0;
        o_m_bresp   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            o_m_awready[i] = aw_act_s && grant_r[i] && i_s_awready;
            o_m_wready[i]  = w_act_s && grant_r[i] && i_s_wready;
            o_m_bvalid[i]  = resp_s && grant_r[i] && i_s_bvalid;
            if (resp_s && grant_r[i]) begin
                o_m_bresp[i*2 +: 2] = i_s_bresp;
            end else begin
                o_m_bresp[i*2 +: 2] = RESP_OKAY;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, track AW/W completion, release on B handshake.
    always_comb begin
        state_n     = state_r;
        grant_n     = grant_r;
        grant_idx_n = grant_idx_r;
        rr_ptr_n    = rr_ptr_r;
        aw_done_n   = aw_done_r;
        w_done_n    = w_done_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    grant_n     = arb_grant_s;
                    grant_idx_n = arb_idx_s;
                    state_n     = ST_XFER;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (aw_hs_s) begin
                    aw_done_n = 1'b1;
                end else begin
                    aw_done_n = aw_done_r;
                end
                if (w_hs_s) begin
                    w_done_n = 1'b1;
                end else begin
                    w_done_n = w_done_r;
                end
                if (aw_done_n && w_done_n) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_XFER;
                end
            end
            ST_RESP: begin
                if (b_hs_s) begin
                    state_n   = ST_IDLE;
                    grant_n   = '0;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    if (grant_idx_r == IDX_W'(NUM_MASTERS - 1)) begin
                        rr_ptr_n = '0;
                    end else begin
                        rr_ptr_n = grant_idx_r + IDX_W'(1);
                    end
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                grant_n   = '0;
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
            end
        endcase
    end

    // State and flag registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            grant_idx_r <= '0;
            rr_ptr_r    <= '0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            grant_r     <= grant_n;
            grant_idx_r <= grant_idx_n;
            rr_ptr_r    <= rr_ptr_n;
            aw_done_r   <= aw_done_n;
            w_done_r    <= w_done_n;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed, table-driven bench for axi_wr_arbiter with two masters; each table
// row is one clock cycle of inputs and the outputs expected in that cycle.
module tb_axi_wr_arbiter;
    import axi_wr_arbiter_pkg::*;

    localparam logic [31:0] A0 = 32'hA000_03F8;
    localparam logic [31:0] A1 = 32'h1000_0010;
    localparam logic [31:0] D0 = 32'h0000_0041;
    localparam logic [31:0] D1 = 32'h0000_0055;
    localparam logic [7:0]  S0 = 8'h01;
    localparam logic [7:0]  S1 = 8'h0F;
    localparam int          NV = 33;

    typedef struct {
        logic [1:0] mav, mwv, mbr;
        logic       sar, swr, sbv;
        logic [1:0] sbr;
        logic [1:0] e_mar, e_mwr, e_mbv;
        logic [3:0] e_mbresp;
        logic       e_sav, e_swv, e_sbrdy;
        logic [1:0] e_g;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] m_awaddr;
    logic [1:0]  m_awvalid, m_awready;
    logic [63:0] m_wdata;
    logic [15:0] m_wstrb;
    logic [1:0]  m_wvalid, m_wready;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid, m_bready;
    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;

    int   pass_cnt;
    int   total_cnt;
    vec_t tbl [NV];

    axi_wr_arbiter #(
        .NUM_MASTERS (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .STRB_W      (8)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_m_awaddr  (m_awaddr),
        .i_m_awvalid (m_awvalid),
        .o_m_awready (m_awready),
        .i_m_wdata   (m_wdata),
        .i_m_wstrb   (m_wstrb),
        .i_m_wvalid  (m_wvalid),
        .o_m_wready  (m_wready),
        .o_m_bresp   (m_bresp),
        .o_m_bvalid  (m_bvalid),
        .i_m_bready  (m_bready),
        .o_s_awaddr  (s_awaddr),
        .o_s_awvalid (s_awvalid),
        .i_s_awready (s_awready),
        .o_s_wdata   (s_wdata),
        .o_s_wstrb   (s_wstrb),
        .o_s_wvalid  (s_wvalid),
        .i_s_wready  (s_wready),
        .i_s_bresp   (s_bresp),
        .i_s_bvalid  (s_bvalid),
        .o_s_bready  (s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [1:0] mav, input logic [1:0] mwv, input logic [1:0] mbr,
        input logic sar, input logic swr, input logic sbv, input logic [1:0] sbr,
        input logic [1:0] e_mar, input logic [1:0] e_mwr, input logic [1:0] e_mbv,
        input logic [3:0] e_mbresp, input logic e_sav, input logic e_swv,
        input logic e_sbrdy, input logic [1:0] e_g);
        vec_t v;
        v.mav = mav; v.mwv = mwv; v.mbr = mbr;
        v.sar = sar; v.swr = swr; v.sbv = sbv; v.sbr = sbr;
        v.e_mar = e_mar; v.e_mwr = e_mwr; v.e_mbv = e_mbv; v.e_mbresp = e_mbresp;
        v.e_sav = e_sav; v.e_swv = e_swv; v.e_sbrdy = e_sbrdy; v.e_g = e_g;
        return v;
    endfunction

    function automatic logic [84:0] outs();
        return {m_awready, m_wready, m_bvalid, m_bresp, s_awvalid, s_wvalid, s_bready,
                s_awaddr, s_wdata, s_wstrb};
    endfunction

    function automatic logic [84:0] expect_of(input vec_t v);
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  s;
        a = (v.e_g == 2'b01) ? A0 : ((v.e_g == 2'b10) ? A1 : 32'h0);
        d = (v.e_g == 2'b01) ? D0 : ((v.e_g == 2'b10) ? D1 : 32'h0);
        s = (v.e_g == 2'b01) ? S0 : ((v.e_g == 2'b10) ? S1 : 8'h00);
        return {v.e_mar, v.e_mwr, v.e_mbv, v.e_mbresp, v.e_sav, v.e_swv, v.e_sbrdy,
                v.e_sav ? a : 32'h0, v.e_swv ? d : 32'h0, v.e_swv ? s : 8'h00};
    endfunction

    task automatic check(input string nm, input logic [84:0] act, input logic [84:0] exp_v);
        total_cnt++;
        if (act === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v);
        m_awvalid = v.mav;
        m_wvalid  = v.mwv;
        m_bready  = v.mbr;
        s_awready = v.sar;
        s_wready  = v.swr;
        s_bvalid  = v.sbv;
        s_bresp   = v.sbr;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        m_awaddr  = {A1, A0};
        m_wdata   = {D1, D0};
        m_wstrb   = {S1, S0};
        // Columns: mav mwv mbr sar swr sbv sbr | mar mwr mbv bresp sav swv sbrdy granted
        // Contention from rr_ptr=0: M0 then M1.
        tbl[0]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[1]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b01, 2'b01, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01);
        tbl[2]  = mk(2'b10, 2'b10, 2'b11, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00);
        tbl[3]  = mk(2'b10, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[4]  = mk(2'b10, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b10, 2'b10, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b10);
        tbl[5]  = mk(2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00);
        // Single M0 transaction.
        tbl[6]  = mk(2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[7]  = mk(2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b01, 2'b01, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01);
        tbl[8]  = mk(2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00);
        // Tie with rr_ptr=1: M1 wins.
        tbl[9]  = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[10] = mk(2'b11, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b10, 2'b10, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b10);
        tbl[11] = mk(2'b01, 2'b01, 2'b11, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00);
        // Split AW/W on M0: AW accepted in cycle 2, W in cycle 5.
        tbl[12] = mk(2'b01, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[13] = mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01);
        tbl[14] = mk(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, RESP_OKAY,   2'b01, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01);
        tbl[15] = mk(2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01);
        tbl[16] = mk(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01);
        tbl[17] = mk(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b01, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b01);
        // B backpressure from M0 for 3 cycles while M1 requests.
        tbl[18] = mk(2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[19] = mk(2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[20] = mk(2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[21] = mk(2'b10, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, RESP_OKAY,   2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00);
        // M1 transaction answered with SLVERR.
        tbl[22] = mk(2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[23] = mk(2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b10, 2'b10, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b10);
        tbl[24] = mk(2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, RESP_SLVERR, 2'b00, 2'b00, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b1, 2'b00);
        // W-only master never requests.
        tbl[25] = mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[26] = mk(2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[27] = mk(2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        // M0 with DECERR, leaving rr_ptr=1; then M1 parked in XFER.
        tbl[28] = mk(2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[29] = mk(2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, RESP_OKAY,   2'b01, 2'b01, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b01);
        tbl[30] = mk(2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, RESP_DECERR, 2'b00, 2'b00, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b1, 2'b00);
        tbl[31] = mk(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[32] = mk(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, RESP_OKAY,   2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b10);

        rst_n     = 1'b0;
        m_awvalid = 2'b00;
        m_wvalid  = 2'b00;
        m_bready  = 2'b00;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", outs(), 85'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check($sformatf("row%0d", i), outs(), expect_of(tbl[i]));
        end

        // Reset while M1 sits in XFER: outputs drop at once, rr_ptr returns to 0.
        rst_n = 1'b0;
        #1;
        check("reset_mid_xfer", outs(), 85'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        m_awvalid = 2'b11;
        m_wvalid  = 2'b11;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        #1;
        check("idle_after_reset", outs(), 85'h0);
        @(negedge clk);
        #1;
        check("ptr_cleared_by_reset", {83'h0, m_awready}, {83'h0, 2'b01});
        check("addr_after_reset", {53'h0, s_awaddr}, {53'h0, A0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
